// File: rtl/sys_cmd_if.sv
// Command, UART byte and response signals between sys_cmd_master and its host/UART.
interface sys_cmd_if #(
   parameter int DATA_WIDTH = 8,
   parameter int RF_ADDR    = 4
);
   logic                    CMD_VLD;
   logic                    CMD_RDY;
   logic [1:0]              CMD_TYPE;
   logic [RF_ADDR-1:0]      CMD_ADDR;
   logic [DATA_WIDTH-1:0]   CMD_WDATA;
   logic [DATA_WIDTH-1:0]   CMD_OPA;
   logic [DATA_WIDTH-1:0]   CMD_OPB;
   logic [3:0]              CMD_FUN;
   logic [DATA_WIDTH-1:0]   TX_DATA;
   logic                    TX_VLD;
   logic                    TX_RDY;
   logic [DATA_WIDTH-1:0]   RX_DATA;
   logic                    RX_VLD;
   logic [2*DATA_WIDTH-1:0] RSP_DATA;
   logic                    RSP_VLD;
   logic                    RSP_TIMEOUT;
   logic                    BUSY;

   modport master (
      input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OPA, CMD_OPB, CMD_FUN,
      input  TX_RDY, RX_DATA, RX_VLD,
      output CMD_RDY, TX_DATA, TX_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT, BUSY
   );

   modport slave (
      output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OPA, CMD_OPB, CMD_FUN,
      output TX_RDY, RX_DATA, RX_VLD,
      input  CMD_RDY, TX_DATA, TX_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT, BUSY
   );
endinterface

// File: rtl/sys_cmd_master.sv
// Host-side command initiator: frames one command into UART bytes and collects the response.
//   state      | meaning
//   S_IDLE     | ready for a command, CMD_RDY high
//   S_SEND     | presenting frame bytes on TX
//   S_WAIT_RSP | collecting response bytes, timeout counter running
//   S_DONE     | one cycle; response pulse is registered out of this state
module sys_cmd_master #(
   parameter int DATA_WIDTH  = 8,
   parameter int RF_ADDR     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic      CLK,
   input  logic      RST,
   sys_cmd_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] HDR_ALU = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] HDR_FUN = DATA_WIDTH'(8'hDD);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SEND     = 2'd1,
      S_WAIT_RSP = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   frame_q [4];
   logic [DATA_WIDTH-1:0]   frame_d [4];
   logic [1:0]              last_idx_q, last_idx_d;
   logic [1:0]              idx_q, idx_d;
   logic [1:0]              need_q, need_d;
   logic [1:0]              rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0]        tcnt_q, tcnt_d;
   logic                    tflag_q, tflag_d;
   logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                    rsp_vld_q, rsp_vld_d;
   logic                    rsp_to_q, rsp_to_d;

   logic [DATA_WIDTH-1:0]   addr_byte;
   logic [DATA_WIDTH-1:0]   fun_byte;

   assign addr_byte = {{(DATA_WIDTH-RF_ADDR){1'b0}}, bus.CMD_ADDR};
   assign fun_byte  = {{(DATA_WIDTH-4){1'b0}}, bus.CMD_FUN};

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      last_idx_d = last_idx_q;
      idx_d      = idx_q;
      need_d     = need_q;
      rx_cnt_d   = rx_cnt_q;
      tcnt_d     = tcnt_q;
      tflag_d    = tflag_q;
      rsp_data_d = rsp_data_q;
      rsp_vld_d  = 1'b0;
      rsp_to_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.CMD_VLD) begin
               rsp_data_d = '0;
               idx_d      = 2'd0;
               rx_cnt_d   = 2'd0;
               tcnt_d     = '0;
               tflag_d    = 1'b0;
               state_d    = S_SEND;
               frame_d[2] = '0;
               frame_d[3] = '0;
               case (bus.CMD_TYPE)
                  2'd0: begin
                     frame_d[0] = HDR_WR;
                     frame_d[1] = addr_byte;
                     frame_d[2] = bus.CMD_WDATA;
                     last_idx_d = 2'd2;
                     need_d     = 2'd0;
                  end
                  2'd1: begin
                     frame_d[0] = HDR_RD;
                     frame_d[1] = addr_byte;
                     last_idx_d = 2'd1;
                     need_d     = 2'd1;
                  end
                  2'd2: begin
                     frame_d[0] = HDR_ALU;
                     frame_d[1] = bus.CMD_OPA;
                     frame_d[2] = bus.CMD_OPB;
                     frame_d[3] = fun_byte;
                     last_idx_d = 2'd3;
                     need_d     = 2'd2;
                  end
                  default: begin
                     frame_d[0] = HDR_FUN;
                     frame_d[1] = fun_byte;
                     last_idx_d = 2'd1;
                     need_d     = 2'd2;
                  end
               endcase
            end
         end
         S_SEND: begin
            if (bus.TX_RDY) begin
               if (idx_q == last_idx_q) begin
                  state_d = (need_q == 2'd0) ? S_DONE : S_WAIT_RSP;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         S_WAIT_RSP: begin
            // A byte arriving on the limit cycle takes priority over the timeout.
            if (bus.RX_VLD) begin
               if (rx_cnt_q[0]) rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = bus.RX_DATA;
               else             rsp_data_d[DATA_WIDTH-1:0]            = bus.RX_DATA;
               rx_cnt_d = rx_cnt_q + 2'd1;
               tcnt_d   = '0;
               if (rx_cnt_d == need_q) state_d = S_DONE;
            end else begin
               tcnt_d = tcnt_q + CNT_W'(1);
               if (tcnt_d == CNT_LIMIT) begin
                  tflag_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            rsp_vld_d = 1'b1;
            rsp_to_d  = tflag_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         frame_q    <= '{default: '0};
         last_idx_q <= 2'd0;
         idx_q      <= 2'd0;
         need_q     <= 2'd0;
         rx_cnt_q   <= 2'd0;
         tcnt_q     <= '0;
         tflag_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_to_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         last_idx_q <= last_idx_d;
         idx_q      <= idx_d;
         need_q     <= need_d;
         rx_cnt_q   <= rx_cnt_d;
         tcnt_q     <= tcnt_d;
         tflag_q    <= tflag_d;
         rsp_data_q <= rsp_data_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_to_q   <= rsp_to_d;
      end
   end

   assign bus.CMD_RDY     = (state_q == S_IDLE);
   assign bus.BUSY        = (state_q != S_IDLE);
   assign bus.TX_VLD      = (state_q == S_SEND);
   assign bus.TX_DATA     = (state_q == S_SEND) ? frame_q[idx_q] : '0;
   assign bus.RSP_DATA    = rsp_data_q;
   assign bus.RSP_VLD     = rsp_vld_q;
   assign bus.RSP_TIMEOUT = rsp_to_q;

endmodule

// File: tb/tb_sys_cmd_master.sv
// Bench for sys_cmd_master: transaction-level model compared every cycle, directed literal cases, random traffic.
module tb_sys_cmd_master;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 32;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   sys_cmd_if #(.DATA_WIDTH(DW), .RF_ADDR(AW)) bus ();

   sys_cmd_master #(.DATA_WIDTH(DW), .RF_ADDR(AW), .TIMEOUT_CYC(TO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   // model: bytes still to send, response bytes awaited, idle cycles seen, done countdown
   logic [7:0]  txq [$];
   int          m_need, m_got, m_idle;
   bit          m_waiting, m_done_cyc, m_pulse, m_to;
   logic [15:0] m_rsp;

   logic [7:0]  tx_log [$];
   int          tx_cyc [$];
   logic [15:0] rsp_dat_log [$];
   bit          rsp_to_log [$];
   int          rsp_cyc_log [$];
   int          acc_cnt = 0;
   int          acc_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      txq.delete();
      m_need = 0; m_got = 0; m_idle = 0;
      m_waiting = 0; m_done_cyc = 0; m_pulse = 0; m_to = 0;
      m_rsp = '0;
   endfunction

   function automatic void model_step();
      bit pulse_n = 0;
      if (m_done_cyc) begin
         m_done_cyc = 0;
         pulse_n    = 1;
      end else if (txq.size() > 0) begin
         if (bus.TX_RDY) begin
            void'(txq.pop_front());
            if (txq.size() == 0) begin
               if (m_need == 0) m_done_cyc = 1;
               else begin m_waiting = 1; m_idle = 0; end
            end
         end
      end else if (m_waiting) begin
         if (bus.RX_VLD) begin
            m_rsp[8*m_got +: 8] = bus.RX_DATA;
            m_got++;
            m_idle = 0;
            if (m_got == m_need) begin m_waiting = 0; m_done_cyc = 1; end
         end else begin
            m_idle++;
            if (m_idle == TO - 1) begin m_waiting = 0; m_done_cyc = 1; m_to = 1; end
         end
      end else if (bus.CMD_VLD) begin
         m_rsp = '0; m_got = 0; m_to = 0; m_idle = 0;
         txq.delete();
         case (bus.CMD_TYPE)
            2'd0: begin
               txq.push_back(8'hAA); txq.push_back({4'h0, bus.CMD_ADDR});
               txq.push_back(bus.CMD_WDATA); m_need = 0;
            end
            2'd1: begin
               txq.push_back(8'hBB); txq.push_back({4'h0, bus.CMD_ADDR}); m_need = 1;
            end
            2'd2: begin
               txq.push_back(8'hCC); txq.push_back(bus.CMD_OPA);
               txq.push_back(bus.CMD_OPB); txq.push_back({4'h0, bus.CMD_FUN}); m_need = 2;
            end
            default: begin
               txq.push_back(8'hDD); txq.push_back({4'h0, bus.CMD_FUN}); m_need = 2;
            end
         endcase
      end
      m_pulse = pulse_n;
   endfunction

   always @(negedge CLK) begin
      bit busy_e;
      if (!RST) model_reset();
      busy_e = (txq.size() > 0) || m_waiting || m_done_cyc;
      chk("cmd_rdy",  32'(bus.CMD_RDY),     32'(!busy_e));
      chk("busy",     32'(bus.BUSY),        32'(busy_e));
      chk("tx_vld",   32'(bus.TX_VLD),      32'(txq.size() > 0));
      chk("tx_data",  32'(bus.TX_DATA),     32'((txq.size() > 0) ? txq[0] : 8'h00));
      chk("rsp_data", 32'(bus.RSP_DATA),    32'(m_rsp));
      chk("rsp_vld",  32'(bus.RSP_VLD),     32'(m_pulse));
      chk("rsp_to",   32'(bus.RSP_TIMEOUT), 32'(m_pulse && m_to));
      if (RST) begin
         if (bus.TX_VLD && bus.TX_RDY) begin tx_log.push_back(bus.TX_DATA); tx_cyc.push_back(cyc); end
         if (bus.RSP_VLD) begin
            rsp_dat_log.push_back(bus.RSP_DATA);
            rsp_to_log.push_back(bus.RSP_TIMEOUT);
            rsp_cyc_log.push_back(cyc);
         end
         if (bus.CMD_VLD && bus.CMD_RDY) begin acc_cnt++; acc_cyc = cyc; end
         model_step();
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                        input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
      int k = 0;
      while (!bus.CMD_RDY && k < 100) begin tick(); k++; end
      chk("issue_rdy", 32'(bus.CMD_RDY), 32'd1);
      bus.CMD_TYPE = t; bus.CMD_ADDR = a; bus.CMD_WDATA = wd;
      bus.CMD_OPA = oa; bus.CMD_OPB = ob; bus.CMD_FUN = f;
      bus.CMD_VLD = 1'b1;
      tick();
      bus.CMD_VLD = 1'b0;
   endtask

   task automatic wait_tx(input int n);
      int k = 0;
      while (tx_log.size() < n && k < 200) begin tick(); k++; end
      chk("tx_wait", 32'(tx_log.size() >= n), 32'd1);
   endtask

   task automatic wait_rsp(input int n);
      int k = 0;
      while (rsp_dat_log.size() < n && k < 200 + TO) begin tick(); k++; end
      chk("rsp_wait", 32'(rsp_dat_log.size() >= n), 32'd1);
   endtask

   task automatic rx_byte(input logic [7:0] d);
      bus.RX_DATA = d; bus.RX_VLD = 1'b1;
      tick();
      bus.RX_VLD = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int tb, rb, a0, rx_c, rpct;
      bus.CMD_VLD = 0; bus.CMD_TYPE = 0; bus.CMD_ADDR = 0; bus.CMD_WDATA = 0;
      bus.CMD_OPA = 0; bus.CMD_OPB = 0; bus.CMD_FUN = 0;
      bus.TX_RDY = 0; bus.RX_DATA = 0; bus.RX_VLD = 0;
      repeat (3) tick();
      RST = 1'b1;
      tick();

      // write: AA 05 3C back to back, pulse at accept+5, no data
      bus.TX_RDY = 1'b1;
      tb = tx_log.size(); rb = rsp_dat_log.size();
      issue(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
      wait_rsp(rb + 1);
      chk("wr_b0", 32'(tx_log[tb]), 32'hAA);
      chk("wr_b1", 32'(tx_log[tb+1]), 32'h05);
      chk("wr_b2", 32'(tx_log[tb+2]), 32'h3C);
      chk("wr_b0_cyc", 32'(tx_cyc[tb] - acc_cyc), 32'd1);
      chk("wr_b2_cyc", 32'(tx_cyc[tb+2] - acc_cyc), 32'd3);
      chk("wr_rsp_cyc", 32'(rsp_cyc_log[rb] - acc_cyc), 32'd5);
      chk("wr_rsp_data", 32'(rsp_dat_log[rb]), 32'h0);
      chk("wr_rsp_to", 32'(rsp_to_log[rb]), 32'd0);

      // read with a late response byte
      tb = tx_log.size(); rb = rsp_dat_log.size();
      issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
      wait_tx(tb + 2);
      repeat (19) tick();
      rx_byte(8'h81);
      wait_rsp(rb + 1);
      chk("rd_b0", 32'(tx_log[tb]), 32'hBB);
      chk("rd_b1", 32'(tx_log[tb+1]), 32'h02);
      chk("rd_rsp_data", 32'(rsp_dat_log[rb]), 32'h0081);
      chk("rd_rsp_to", 32'(rsp_to_log[rb]), 32'd0);

      // ALU with operands under TX back-pressure
      tb = tx_log.size(); rb = rsp_dat_log.size();
      issue(2'd2, 4'h0, 8'h00, 8'h10, 8'h05, 4'h2);
      for (int k = 0; k < 60 && tx_log.size() < tb + 4; k++) begin
         bus.TX_RDY = ~bus.TX_RDY;
         tick();
      end
      bus.TX_RDY = 1'b1;
      repeat (3) tick();
      rx_byte(8'h50);
      repeat (2) tick();
      rx_byte(8'h00);
      wait_rsp(rb + 1);
      chk("alu_b0", 32'(tx_log[tb]), 32'hCC);
      chk("alu_b1", 32'(tx_log[tb+1]), 32'h10);
      chk("alu_b2", 32'(tx_log[tb+2]), 32'h05);
      chk("alu_b3", 32'(tx_log[tb+3]), 32'h02);
      chk("alu_rsp_data", 32'(rsp_dat_log[rb]), 32'h0050);
      chk("alu_rsp_to", 32'(rsp_to_log[rb]), 32'd0);

      // ALU without operands, second byte never comes
      tb = tx_log.size(); rb = rsp_dat_log.size();
      issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0);
      wait_tx(tb + 2);
      repeat (2) tick();
      rx_c = cyc;
      rx_byte(8'h15);
      wait_rsp(rb + 1);
      chk("to_b0", 32'(tx_log[tb]), 32'hDD);
      chk("to_b1", 32'(tx_log[tb+1]), 32'h00);
      chk("to_rsp_cyc", 32'(rsp_cyc_log[rb] - rx_c), 32'(TO + 1));
      chk("to_rsp_data", 32'(rsp_dat_log[rb]), 32'h0015);
      chk("to_rsp_to", 32'(rsp_to_log[rb]), 32'd1);

      // unsolicited RX in IDLE and CMD_VLD held during SEND
      rx_byte(8'hEE);
      tick();
      a0 = acc_cnt; tb = tx_log.size(); rb = rsp_dat_log.size();
      issue(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0);
      bus.CMD_TYPE = 2'd0; bus.CMD_ADDR = 4'hF; bus.CMD_WDATA = 8'h99; bus.CMD_VLD = 1'b1;
      bus.TX_RDY = 1'b0;
      repeat (3) tick();
      bus.TX_RDY = 1'b1;
      wait_tx(tb + 2);
      bus.CMD_VLD = 1'b0;
      rx_byte(8'h42);
      wait_rsp(rb + 1);
      chk("ign_acc_cnt", 32'(acc_cnt - a0), 32'd1);
      chk("ign_b0", 32'(tx_log[tb]), 32'hBB);
      chk("ign_b1", 32'(tx_log[tb+1]), 32'h07);
      chk("ign_rsp_data", 32'(rsp_dat_log[rb]), 32'h0042);

      // reset during byte 2 of a CC frame, then a clean read
      tb = tx_log.size();
      issue(2'd2, 4'h0, 8'h00, 8'hA1, 8'hB2, 4'h3);
      wait_tx(tb + 1);
      RST = 1'b0;
      #1;
      chk("rst_tx_vld", 32'(bus.TX_VLD), 32'd0);
      chk("rst_cmd_rdy", 32'(bus.CMD_RDY), 32'd1);
      repeat (2) tick();
      RST = 1'b1;
      rb = rsp_dat_log.size();
      repeat (40) tick();
      chk("rst_no_rsp", 32'(rsp_dat_log.size() - rb), 32'd0);
      issue(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
      wait_tx(tx_log.size() + 2);
      rx_byte(8'h99);
      wait_rsp(rb + 1);
      chk("rst_rd_data", 32'(rsp_dat_log[rb]), 32'h0099);

      // random traffic against the model
      for (int e = 0; e < 40; e++) begin
         case ($urandom_range(0, 2))
            0:       rpct = 0;
            1:       rpct = 4;
            default: rpct = 25;
         endcase
         for (int c = 0; c < 150; c++) begin
            bus.CMD_VLD   = ($urandom_range(0, 99) < 30);
            bus.CMD_TYPE  = 2'($urandom_range(0, 3));
            bus.CMD_ADDR  = 4'($urandom);
            bus.CMD_WDATA = 8'($urandom);
            bus.CMD_OPA   = 8'($urandom);
            bus.CMD_OPB   = 8'($urandom);
            bus.CMD_FUN   = 4'($urandom);
            bus.TX_RDY    = ($urandom_range(0, 99) < 75);
            bus.RX_VLD    = ($urandom_range(0, 99) < rpct);
            bus.RX_DATA   = 8'($urandom);
            tick();
         end
      end
      bus.CMD_VLD = 1'b0; bus.RX_VLD = 1'b0; bus.TX_RDY = 1'b1;
      repeat (TO + 20) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sys_cmd_master.md
Name: sys_cmd_master

Overview:
- Host-side command initiator for the UART command protocol that the system controller decodes. It is the other end of that link.
- Accepts one command at a time on a parallel request port and serializes it into the framed byte sequence: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands.
- Collects the response bytes that come back from the UART receiver, then returns a single response or a timeout.
- Sits between a test/host sequencer and a UART TX/RX pair, all in one clock domain.

Parameters:
- DATA_WIDTH, 8, byte width of the UART payload.
- RF_ADDR, 4, register-file address width; the address is zero-extended into its byte.
- TIMEOUT_CYC, 1024, number of idle CLK cycles allowed while waiting for each response byte.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- CMD_VLD  in  1  command request.
- CMD_RDY  out  1  block can accept a command (high only in IDLE).
- CMD_TYPE  in  2  command type: 0 = write, 1 = read, 2 = ALU with operands, 3 = ALU without operands.
- CMD_ADDR  in  RF_ADDR  register address (write/read).
- CMD_WDATA  in  DATA_WIDTH  write data.
- CMD_OPA  in  DATA_WIDTH  operand A.
- CMD_OPB  in  DATA_WIDTH  operand B.
- CMD_FUN  in  4  ALU function code.
- TX_DATA  out  DATA_WIDTH  byte toward the UART TX.
- TX_VLD  out  1  TX_DATA valid.
- TX_RDY  in  1  UART TX can take a byte.
- RX_DATA  in  DATA_WIDTH  byte from the UART RX.
- RX_VLD  in  1  one-cycle pulse marking RX_DATA valid.
- RSP_DATA  out  2*DATA_WIDTH  response value.
- RSP_VLD  out  1  one-cycle pulse: command complete.
- RSP_TIMEOUT  out  1  one-cycle pulse, coincident with RSP_VLD, when a response byte did not arrive in time.
- BUSY  out  1  high whenever the block is not in IDLE.

Behaviour:
- Reset (async, RST low):
  - State IDLE.
  - CMD_RDY=1, TX_VLD=0, TX_DATA=0, RSP_DATA=0, RSP_VLD=0, RSP_TIMEOUT=0, BUSY=0.
  - Byte index, timeout counter and byte count cleared.
  - Asserting reset mid-frame aborts the command; no RSP_VLD is issued for it.
- Command accept:
  - A command is accepted on the cycle where CMD_VLD=1 and CMD_RDY=1.
  - All CMD_* fields are registered that cycle; later changes to the inputs have no effect.
  - Frame length is set from CMD_TYPE: 3 / 2 / 4 / 2 bytes for types 0 / 1 / 2 / 3.
- Frames, bytes in transmit order:
  - write: 0xAA, {0,ADDR}, WDATA.
  - read: 0xBB, {0,ADDR}.
  - ALU with operands: 0xCC, OPA, OPB, {4'h0,FUN}.
  - ALU without operands: 0xDD, {4'h0,FUN}.
- States: IDLE -> SEND -> (WAIT_RSP) -> DONE -> IDLE.
- SEND:
  - TX_VLD=1 with TX_DATA set to the current frame byte.
  - A byte transfers on a cycle where TX_VLD=1 and TX_RDY=1. The index then advances and the next byte is presented on the following cycle; TX_VLD stays high.
  - TX_DATA is stable while TX_VLD=1 and TX_RDY=0.
  - After the last byte transfers, TX_VLD drops the next cycle. Write goes to DONE; all other types go to WAIT_RSP.
- WAIT_RSP:
  - Expected response bytes: read = 1, ALU = 2 (LSB first).
  - Each RX_VLD pulse stores RX_DATA into the next byte lane of RSP_DATA and clears the timeout counter.
  - Read response: RSP_DATA = {8'h00, byte}.
  - When all expected bytes are received, go to DONE.
  - The timeout counter increments every cycle without RX_VLD. When it reaches TIMEOUT_CYC-1, go to DONE with the timeout flag set; RSP_DATA keeps whatever bytes were already captured, with missing lanes at 0.
  - If RX_VLD arrives in the same cycle the counter reaches its limit, the byte wins: it is captured and no timeout occurs.
- DONE (one cycle):
  - RSP_VLD=1; RSP_TIMEOUT=1 if the timeout flag is set.
  - Next state IDLE. CMD_RDY returns to 1 the cycle after DONE.
  - Write: RSP_DATA=0 and RSP_VLD pulses after the final byte transfers.
- RSP_DATA holds its value until the next command is accepted, where it is cleared to 0.
- RX_VLD outside WAIT_RSP (unsolicited byte) is ignored, with no state change.
- CMD_VLD while CMD_RDY=0 is ignored; it is neither queued nor flagged.
- Minimum latency for a write with TX_RDY tied high: accept at cycle 0, bytes transfer at cycles 1–3, RSP_VLD at cycle 5.

Test Plan:
- Write ADDR=4'h5, WDATA=0x3C, TX_RDY=1 -> TX bytes AA,05,3C on consecutive cycles; RSP_VLD pulses once with RSP_DATA=0 and RSP_TIMEOUT=0; no wait for RX.
- Read ADDR=4'h2; inject RX byte 0x81 twenty cycles after the last TX byte -> TX bytes BB,02; RSP_DATA=0x0081, RSP_VLD=1, RSP_TIMEOUT=0.
- ALU with operands OPA=0x10, OPB=0x05, FUN=4'h2, TX_RDY toggling 1-0-1 -> TX bytes CC,10,05,02 with TX_DATA stable while stalled; RX bytes 0x50 then 0x00 -> RSP_DATA=0x0050.
- ALU without operands FUN=4'h0, only one RX byte 0x15 sent -> RSP_VLD and RSP_TIMEOUT pulse together exactly TIMEOUT_CYC cycles after that byte; RSP_DATA=0x0015.
- Unsolicited RX_VLD in IDLE, plus CMD_VLD asserted during SEND -> neither affects the active command; CMD_RDY stays 0 until after DONE.
- RST asserted low during byte 2 of a CC frame -> TX_VLD=0, CMD_RDY=1, no RSP_VLD; a fresh read afterwards completes normally.
